// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 SDF FFT butterfly: phase encoding, widths, complex sample.
// SDF_BFLY16_SAT_EN selects clamping (defined) or wrap-around (undefined) of multiplier results.
package fft_pkg;

  localparam int IN_W    = 8;
  localparam int OUT_W   = 9;
  localparam int TW_W    = 8;
  localparam int TW_FRAC = 6;

  // Wide enough for dr*wr - di*wi with 9-bit data and 8-bit twiddles, plus the rounding offset.
  localparam int PROD_W    = OUT_W + TW_W + 1;
  localparam int ROUND_OFS = 1 << (TW_FRAC - 1);

`ifdef SDF_BFLY16_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_FIRST   = 2'b01,
    ST_SECOND  = 2'b10,
    ST_WAITING = 2'b11
  } state_e;

  typedef struct packed {
    logic signed [OUT_W-1:0] re;
    logic signed [OUT_W-1:0] im;
  } cplx_t;

endpackage

// File: rtl/sdf_bfly16_mul.sv
// Combinational complex multiply by a Q2.6 twiddle with round-half-up rescaling to 9 bits.
// SDF_BFLY16_SAT_EN clamps out-of-range results and flags them; otherwise results wrap.
module cplx_mul_q26
  import fft_pkg::*;
(
  input  logic signed [OUT_W-1:0] dr_i,
  input  logic signed [OUT_W-1:0] di_i,
  input  logic signed [TW_W-1:0]  wr_i,
  input  logic signed [TW_W-1:0]  wi_i,
  output logic signed [OUT_W-1:0] pr_o,
  output logic signed [OUT_W-1:0] pi_o,
  output logic                    sat_o
);

  logic signed [PROD_W-1:0] drx, dix, wrx, wix;
  logic signed [PROD_W-1:0] re_full, im_full;
  logic signed [PROD_W-1:0] re_rnd, im_rnd;
  logic signed [PROD_W-1:0] re_sh, im_sh;
  logic                     re_ovf, im_ovf;

  assign drx = PROD_W'(dr_i);
  assign dix = PROD_W'(di_i);
  assign wrx = PROD_W'(wr_i);
  assign wix = PROD_W'(wi_i);

  assign re_full = (drx * wrx) - (dix * wix);
  assign im_full = (drx * wix) + (dix * wrx);

  assign re_rnd = re_full + PROD_W'(ROUND_OFS);
  assign im_rnd = im_full + PROD_W'(ROUND_OFS);
  assign re_sh  = re_rnd >>> TW_FRAC;
  assign im_sh  = im_rnd >>> TW_FRAC;

  // A value fits in OUT_W bits when every bit from the OUT_W sign bit upward agrees.
  assign re_ovf = !((&re_sh[PROD_W-1:OUT_W-1]) || !(|re_sh[PROD_W-1:OUT_W-1]));
  assign im_ovf = !((&im_sh[PROD_W-1:OUT_W-1]) || !(|im_sh[PROD_W-1:OUT_W-1]));

  always_comb begin
    pr_o = re_sh[OUT_W-1:0];
    pi_o = im_sh[OUT_W-1:0];
    if (SAT_EN && re_ovf) begin
      pr_o = re_sh[PROD_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
    if (SAT_EN && im_ovf) begin
      pi_o = im_sh[PROD_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  assign sat_o = SAT_EN && (re_ovf || im_ovf);

endmodule

// File: rtl/sdf_bfly16.sv
// Radix-2 DIF single-path delay feedback butterfly with a DEPTH-entry complex shift-register delay line.
// SDF_BFLY16_SAT_EN (see fft_pkg) selects saturating multiplier output and the sat_o pulse.
module sdf_bfly16
  import fft_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_i,
  input  logic [1:0]              state,
  input  logic signed [IN_W-1:0]  a_r,
  input  logic signed [IN_W-1:0]  a_i,
  input  logic signed [TW_W-1:0]  wn_r,
  input  logic signed [TW_W-1:0]  wn_i,
  output logic                    valid_o,
  output logic signed [OUT_W-1:0] out_r,
  output logic signed [OUT_W-1:0] out_i,
  output logic                    sat_o
);

  state_e                  st;
  cplx_t                   line_q [DEPTH];
  cplx_t                   push_d;
  logic                    shift_en;
  cplx_t                   a_ext, d, sum, diff;
  logic signed [OUT_W-1:0] prod_r, prod_i;
  logic                    prod_sat;

  cplx_t out_d, out_q;
  logic  valid_d, valid_q;
  logic  sat_d, sat_q;

  assign st    = state_e'(state);
  assign a_ext = {OUT_W'(a_r), OUT_W'(a_i)};
  assign d     = line_q[DEPTH-1];

  // Operands are 8-bit samples (or their 9-bit difference is never summed again), so 9 bits is exact.
  always_comb begin
    sum.re  = d.re + a_ext.re;
    sum.im  = d.im + a_ext.im;
    diff.re = d.re - a_ext.re;
    diff.im = d.im - a_ext.im;
  end

  cplx_mul_q26 u_mul (
    .dr_i  (d.re),
    .di_i  (d.im),
    .wr_i  (wn_r),
    .wi_i  (wn_i),
    .pr_o  (prod_r),
    .pi_o  (prod_i),
    .sat_o (prod_sat)
  );

  always_comb begin
    push_d   = a_ext;
    shift_en = 1'b0;
    out_d    = '0;
    valid_d  = 1'b0;
    sat_d    = 1'b0;
    unique case (st)
      ST_IDLE: begin
      end
      ST_WAITING: begin
        shift_en = 1'b1;
      end
      ST_FIRST: begin
        shift_en = 1'b1;
        push_d   = diff;
        out_d    = sum;
        valid_d  = valid_i;
      end
      ST_SECOND: begin
        shift_en = 1'b1;
        out_d    = {prod_r, prod_i};
        sat_d    = prod_sat;
        valid_d  = valid_i;
      end
      default: begin
      end
    endcase
  end

  // Entry 0 is the newest sample; the oldest entry at DEPTH-1 feeds the butterfly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        line_q[i] <= '0;
      end
    end else if (shift_en) begin
      line_q[0] <= push_d;
      for (int i = 1; i < DEPTH; i++) begin
        line_q[i] <= line_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
    end
  end

  assign valid_o = valid_q;
  assign out_r   = out_q.re;
  assign out_i   = out_q.im;
  assign sat_o   = sat_q;

endmodule

// File: doc/sdf_bfly16.md
SDF_BFLY16 -- requirements
Module: sdf_bfly16

Interface
REQ-001 Parameter DEPTH, default 16: delay-line length and half-frame size; only 16 is verified.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 valid_i  input  1  upstream controller valid; high while the controller is in FIRST or SECOND.
REQ-005 state  input  2  controller phase: IDLE=00, FIRST=01, SECOND=10, WAITING=11.
REQ-006 a_r, a_i  input  8 each  signed sample, Q5.3, registered upstream and aligned with state.
REQ-007 wn_r, wn_i  input  8 each  signed twiddle, Q2.6; zero outside SECOND.
REQ-008 valid_o  output  1  output sample valid.
REQ-009 out_r, out_i  output  9 each  signed result, Q6.3.
REQ-010 sat_o  output  1  one-cycle pulse when the current output was saturated (only with SDF_BFLY16_SAT_EN).

Function
REQ-011 Datapath is a radix-2 DIF single-path delay feedback butterfly with a DEPTH-entry complex delay line (9-bit real and imaginary); d denotes the oldest entry.
REQ-012 IDLE: delay line holds its contents, valid_o=0, and out_r/out_i are 0.
REQ-013 WAITING: push {sign-extended a} into the delay line; valid_o=0; outputs 0.
REQ-014 FIRST: output g=d+a; push h=d-a; both are 9-bit exact with no overflow possible.
REQ-015 SECOND: output round(d*wn); push sign-extended a, which is the next frame's first half.
REQ-016 Complex multiply:
- re = dr*wr - di*wi; im = dr*wi + di*wr; full precision, 18 bits minimum.
- Rescale: add 32, then arithmetic shift right 6 (round half up).
- Reduce to 9 bits per REQ-024/025.
REQ-017 Latency: out_r/out_i/valid_o are registered one cycle after the state/a/wn that produced them.
REQ-018 valid_o is the registered value of (valid_i AND state in {FIRST, SECOND}).
REQ-019 Back-to-back frames: a SECOND-to-FIRST transition with valid_i held high SHALL produce a gapless valid_o and a correct next frame.
REQ-020 The delay line advances exactly one entry per cycle in WAITING, FIRST and SECOND; no other condition stalls or advances it.
REQ-021 An illegal combination (valid_i=1 in IDLE or WAITING) SHALL NOT raise valid_o.

Reset
REQ-022 On rst_n low: valid_o=0, out_r=0, out_i=0, sat_o=0, and all delay entries are 0, immediately and asynchronously.
REQ-023 Reset asserted mid-frame discards the partial frame; the first frame after release SHALL match a frame from cold reset.

Configuration
REQ-024 SDF_BFLY16_SAT_EN defined:
- Multiplier results outside [-256,255] clamp to the nearest bound.
- sat_o pulses high, aligned with that output.
REQ-025 SDF_BFLY16_SAT_EN undefined:
- Results wrap (keep the low 9 bits).
- sat_o is tied to 0.
- The sum/difference path is identical in both builds.

Structure
REQ-026 Shared package fft_pkg holds:
- the state encoding constants (IDLE/FIRST/SECOND/WAITING);
- the widths IN_W=8, OUT_W=9, TW_W=8, TW_FRAC=6;
- the complex sample typedef.
REQ-027 The complex multiply, rounding and saturation logic lives in one combinational sub-module, cplx_mul_q26, instantiated once.
REQ-028 The delay line is a register shift chain with no RAM.

Verification
REQ-029 Reset: assert rst_n low mid-operation -> outputs, valid_o and sat_o are 0 in the same cycle; the next full frame matches the golden model.
REQ-030 Constant input a=(8,0) for 32 samples:
- FIRST yields (16,0) x16.
- SECOND yields (0,0) x16.
- valid_o is high for exactly 32 cycles.
REQ-031 Step input x[n]=(8,0) for n<16 and (-8,0) for n>=16:
- FIRST outputs (0,0).
- SECOND with wn=(64,0) outputs (16,0).
- SECOND with wn=(0,-64) outputs (0,-16).
REQ-032 Saturation: first half (127,127), second half (-128,-128), wn=(45,-46):
- With the macro: out=(255,-4) and sat_o=1.
- Without the macro: out=(-149,-4) and sat_o=0.
REQ-033 Two back-to-back frames with valid_i held high:
- valid_o stays high for 64 consecutive cycles.
- Frame 2 results equal the golden model, with no cross-frame contamination.
REQ-034 Random frames (1000) against a bit-accurate reference model, including rounding ties (product LSBs = 0x20), and check every output.
